// File: rtl/axilite_cfg_pkg.sv
// Shared constants, types and helpers for the AXI4-Lite configuration register slave.
package axilite_cfg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, HOLD, COMMIT, RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  // Width of the word-index field covering n words (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axilite_cfg_wr_chan.sv
// AXI4-Lite write channel: independent AW/W capture, commit strobe to the register bank, B handshake.
//
// state  | meaning
// IDLE   | nothing held
// HOLD   | AW only or W only held
// COMMIT | both held; register bank writes on the next edge
// RESP   | bvalid high, waiting for bready
module axilite_cfg_wr_chan
  import axilite_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CFG    = 8,
  parameter int NUM_STS    = 8,
  localparam int IDXW      = idx_width(NUM_CFG + NUM_STS)
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  output logic [1:0]              axi_bresp,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  output logic                    wr_commit,
  output logic [IDXW-1:0]         wr_idx,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb
);

  localparam logic [IDXW:0] CFG_LIMIT = (IDXW + 1)'(NUM_CFG);

  wr_state_t               state;
  logic                    aw_held;
  logic                    w_held;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    addr_upper;
  logic                    cfg_hit;
  logic                    unused_addr_bits;

  assign axi_awready = !aw_held && !axi_bvalid;
  assign axi_wready  = !w_held && !axi_bvalid;
  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;

  // Status words and anything outside the index field are not writable.
  assign wr_idx      = awaddr_q[2 +: IDXW];
  assign addr_upper  = |(awaddr_q >> (2 + IDXW));
  assign cfg_hit     = !addr_upper && ({1'b0, wr_idx} < CFG_LIMIT);
  assign wr_commit   = (state == COMMIT) && cfg_hit;
  assign unused_addr_bits = ^awaddr_q[1:0];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      awaddr_q   <= '0;
      wr_data    <= '0;
      wr_strb    <= '0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= axi_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wr_data <= axi_wdata;
        wr_strb <= axi_wstrb;
      end
      case (state)
        IDLE: begin
          if (aw_hs && w_hs)      state <= COMMIT;
          else if (aw_hs || w_hs) state <= HOLD;
        end
        HOLD: begin
          if ((aw_held || aw_hs) && (w_held || w_hs)) state <= COMMIT;
        end
        COMMIT: begin
          state      <= RESP;
          aw_held    <= 1'b0;
          w_held     <= 1'b0;
          axi_bvalid <= 1'b1;
          axi_bresp  <= cfg_hit ? RESP_OKAY : RESP_SLVERR;
        end
        RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axilite_cfg_reg_slave.sv
// AXI4-Lite configuration register slave: R/W cfg bank, read-only status words, SLVERR on
// out-of-range accesses and writes to status words.
module axilite_cfg_reg_slave
  import axilite_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CFG    = 8,
  parameter int NUM_STS    = 8
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]         axi_awaddr,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [DATA_WIDTH-1:0]         axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [ADDR_WIDTH-1:0]         axi_araddr,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [DATA_WIDTH-1:0]         axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  output logic [NUM_CFG*DATA_WIDTH-1:0] cfg_regs,
  output logic [NUM_CFG-1:0]            cfg_wr_pulse,
  input  logic [NUM_STS*DATA_WIDTH-1:0] sts_in
);

  localparam int IDXW = idx_width(NUM_CFG + NUM_STS);

  logic [DATA_WIDTH-1:0]   cfg_q [NUM_CFG];
  logic                    wr_commit;
  logic [IDXW-1:0]         wr_idx;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;

  rd_state_t               rd_state;
  logic [IDXW-1:0]         rd_idx;
  logic                    rd_upper;
  logic [DATA_WIDTH-1:0]   rd_data_nxt;
  logic [1:0]              rd_resp_nxt;
  logic                    unused_addr_bits;

  axilite_cfg_wr_chan #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CFG    (NUM_CFG),
    .NUM_STS    (NUM_STS)
  ) u_wr_chan (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .axi_awaddr  (axi_awaddr),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .wr_commit   (wr_commit),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
      cfg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_wr_pulse[i] <= wr_commit && (wr_idx == IDXW'(i));
        if (wr_commit && (wr_idx == IDXW'(i))) begin
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wr_strb[b]) cfg_q[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < NUM_CFG; i++) cfg_regs[DATA_WIDTH*i +: DATA_WIDTH] = cfg_q[i];
  end

  assign rd_idx   = axi_araddr[2 +: IDXW];
  assign rd_upper = |(axi_araddr >> (2 + IDXW));
  assign unused_addr_bits = ^axi_araddr[1:0];

  // cfg_q is sampled before any same-edge commit lands, so a colliding read sees the old value.
  always_comb begin
    rd_data_nxt = '0;
    rd_resp_nxt = RESP_SLVERR;
    if (!rd_upper) begin
      for (int i = 0; i < NUM_CFG; i++) begin
        if (rd_idx == IDXW'(i)) begin
          rd_data_nxt = cfg_q[i];
          rd_resp_nxt = RESP_OKAY;
        end
      end
      for (int j = 0; j < NUM_STS; j++) begin
        if (rd_idx == IDXW'(NUM_CFG + j)) begin
          rd_data_nxt = sts_in[DATA_WIDTH*j +: DATA_WIDTH];
          rd_resp_nxt = RESP_OKAY;
        end
      end
    end
  end

  assign axi_arready = (rd_state == RD_IDLE);
  assign axi_rvalid  = (rd_state == RD_RESP);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_state  <= RD_IDLE;
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (axi_arvalid) begin
            rd_state  <= RD_RESP;
            axi_rdata <= rd_data_nxt;
            axi_rresp <= rd_resp_nxt;
          end
        end
        RD_RESP: begin
          if (axi_rready) rd_state <= RD_IDLE;
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_cfg_reg_slave.sv
// Self-checking bench for axilite_cfg_reg_slave: vector table plus hand-written corner sequences.
module tb_axilite_cfg_reg_slave;

  localparam int NUM_CFG = 8;
  localparam int NUM_STS = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  axi_awaddr = '0;
  logic         axi_awvalid = 1'b0;
  logic         axi_awready;
  logic [31:0]  axi_wdata = '0;
  logic [3:0]   axi_wstrb = '0;
  logic         axi_wvalid = 1'b0;
  logic         axi_wready;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready = 1'b1;
  logic [31:0]  axi_araddr = '0;
  logic         axi_arvalid = 1'b0;
  logic         axi_arready;
  logic [31:0]  axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rvalid;
  logic         axi_rready = 1'b1;
  logic [NUM_CFG*32-1:0] cfg_regs;
  logic [NUM_CFG-1:0]    cfg_wr_pulse;
  logic [NUM_STS*32-1:0] sts_in = '0;

  always #5 clk = ~clk;

  axilite_cfg_reg_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_CFG    (NUM_CFG),
    .NUM_STS    (NUM_STS)
  ) dut (
    .axi_aclk     (clk),
    .axi_aresetn  (rst_n),
    .axi_awaddr   (axi_awaddr),
    .axi_awvalid  (axi_awvalid),
    .axi_awready  (axi_awready),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_wvalid   (axi_wvalid),
    .axi_wready   (axi_wready),
    .axi_bresp    (axi_bresp),
    .axi_bvalid   (axi_bvalid),
    .axi_bready   (axi_bready),
    .axi_araddr   (axi_araddr),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .cfg_regs     (cfg_regs),
    .cfg_wr_pulse (cfg_wr_pulse),
    .sts_in       (sts_in)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [7:0]  pulse;
  } exp_t;

  vec_t        vecs[$];
  exp_t        wq[$];
  exp_t        rq[$];
  logic [31:0] model [NUM_CFG];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              logic [1:0] er, logic [31:0] ed);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_resp = er; v.exp_rdata = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake did not occur within cycle budget", name);
  endtask

  task automatic check_cfg(input string tag);
    for (int i = 0; i < NUM_CFG; i++)
      check($sformatf("%s cfg_regs[%0d]", tag, i), cfg_regs[32*i +: 32], model[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes the expected B record and updates the register model, then runs AW/W handshakes.
  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er);
    exp_t e;
    int n;
    bit aw_acc, w_acc;
    e.resp  = er;
    e.rdata = '0;
    e.pulse = (er == OKAY) ? (8'b1 << a[4:2]) : 8'h00;
    if (er == OKAY)
      for (int b = 0; b < 4; b++) if (s[b]) model[a[4:2]][8*b +: 8] = d[8*b +: 8];
    wq.push_back(e);
    axi_awaddr = a; axi_awvalid = 1'b1;
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1;
    n = 0;
    while ((axi_awvalid || axi_wvalid) && n < 50) begin
      aw_acc = axi_awvalid && axi_awready;
      w_acc  = axi_wvalid && axi_wready;
      tick();
      n++;
      if (aw_acc) axi_awvalid = 1'b0;
      if (w_acc)  axi_wvalid  = 1'b0;
    end
    if (axi_awvalid || axi_wvalid) begin
      fail_timeout("write_accept");
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
    end
  endtask

  // Called #1 after the acceptance edge; with chk_timing, bvalid and the pulse must appear one edge later.
  task automatic wait_b(input string tag, input bit chk_timing);
    exp_t e;
    int n;
    n = 0;
    axi_bready = 1'b1;
    while (!axi_bvalid && n < 50) begin
      tick();
      n++;
    end
    if (!axi_bvalid) begin
      fail_timeout({tag, " bvalid"});
      return;
    end
    if (wq.size() == 0) begin
      fail_timeout({tag, " unexpected_b"});
      return;
    end
    e = wq.pop_front();
    if (chk_timing) begin
      check({tag, " b_latency"}, n, 1);
      check({tag, " pulse"}, cfg_wr_pulse, e.pulse);
    end
    check({tag, " bresp"}, axi_bresp, e.resp);
    check_cfg(tag);
    tick();
    check({tag, " bvalid_clear"}, axi_bvalid, 1'b0);
    check({tag, " pulse_clear"}, cfg_wr_pulse, 8'h00);
    check({tag, " awready_after_b"}, {axi_awready, axi_wready}, 2'b11);
  endtask

  task automatic write_vec(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    issue_write(a, d, s, er);
    wait_b(tag, 1'b1);
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed);
    exp_t e;
    int n;
    bit acc;
    e.resp = er; e.rdata = ed; e.pulse = '0;
    rq.push_back(e);
    axi_araddr = a; axi_arvalid = 1'b1;
    n = 0;
    while (axi_arvalid && n < 50) begin
      acc = axi_arready;
      tick();
      n++;
      if (acc) axi_arvalid = 1'b0;
    end
    if (axi_arvalid) begin
      fail_timeout("read_accept");
      axi_arvalid = 1'b0;
    end
  endtask

  task automatic wait_r(input string tag);
    exp_t e;
    int n;
    n = 0;
    axi_rready = 1'b1;
    while (!axi_rvalid && n < 50) begin
      tick();
      n++;
    end
    if (!axi_rvalid) begin
      fail_timeout({tag, " rvalid"});
      return;
    end
    if (rq.size() == 0) begin
      fail_timeout({tag, " unexpected_r"});
      return;
    end
    e = rq.pop_front();
    check({tag, " r_latency"}, n, 0);
    check({tag, " rresp"}, axi_rresp, e.resp);
    check({tag, " rdata"}, axi_rdata, e.rdata);
    tick();
    check({tag, " rvalid_clear"}, axi_rvalid, 1'b0);
  endtask

  task automatic read_vec(input string tag, input logic [31:0] a, input logic [1:0] er,
                          input logic [31:0] ed);
    issue_read(a, er, ed);
    wait_r(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_rdata;

    for (int i = 0; i < NUM_CFG; i++) model[i] = '0;
    sts_in[32*0 +: 32] = 32'hCAFE0001;
    sts_in[32*7 +: 32] = 32'h0BADF00D;

    vecs.push_back(mk(1, 32'h0000_0004, 32'hDEADBEEF, 4'hF, OKAY,   '0));
    vecs.push_back(mk(0, 32'h0000_0004, '0,           4'h0, OKAY,   32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h0000_0000, 32'hFFFFFFFF, 4'hF, OKAY,   '0));
    vecs.push_back(mk(0, 32'h0000_0000, '0,           4'h0, OKAY,   32'hFFFFFFFF));
    vecs.push_back(mk(1, 32'h0000_001C, 32'h55AA00FF, 4'h5, OKAY,   '0));
    vecs.push_back(mk(0, 32'h0000_001C, '0,           4'h0, OKAY,   32'h00AA00FF));
    vecs.push_back(mk(0, 32'h0000_0020, '0,           4'h0, OKAY,   32'hCAFE0001));
    vecs.push_back(mk(0, 32'h0000_003C, '0,           4'h0, OKAY,   32'h0BADF00D));
    vecs.push_back(mk(1, 32'h0000_0020, 32'h11111111, 4'hF, SLVERR, '0));
    vecs.push_back(mk(0, 32'h0000_0040, '0,           4'h0, SLVERR, 32'h0));
    vecs.push_back(mk(0, 32'h0000_1000, '0,           4'h0, SLVERR, 32'h0));
    vecs.push_back(mk(1, 32'h0000_1000, 32'h22222222, 4'hF, SLVERR, '0));
    vecs.push_back(mk(0, 32'h0000_0007, '0,           4'h0, OKAY,   32'hDEADBEEF));
    vecs.push_back(mk(1, 32'h0000_000C, 32'h12345678, 4'h0, OKAY,   '0));
    vecs.push_back(mk(0, 32'h0000_000C, '0,           4'h0, OKAY,   32'h0));
    vecs.push_back(mk(1, 32'h0000_0008, 32'hA1B2C3D4, 4'h8, OKAY,   '0));
    vecs.push_back(mk(0, 32'h0000_0008, '0,           4'h0, OKAY,   32'hA1000000));

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset bvalid", axi_bvalid, 1'b0);
    check("reset rvalid", axi_rvalid, 1'b0);
    check("reset bresp", axi_bresp, 2'b00);
    check("reset rresp", axi_rresp, 2'b00);
    check("reset rdata", axi_rdata, 32'h0);
    check("reset pulse", cfg_wr_pulse, 8'h00);
    check_cfg("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("release readies", {axi_awready, axi_wready, axi_arready}, 3'b111);

    for (int k = 0; k < vecs.size(); k++) begin
      if (vecs[k].is_wr)
        write_vec($sformatf("vec%0d", k), vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].exp_resp);
      else
        read_vec($sformatf("vec%0d", k), vecs[k].addr, vecs[k].exp_resp, vecs[k].exp_rdata);
    end

    // W before AW, three idle cycles between them, partial strobe onto reg 0 (0xFFFFFFFF)
    wq.push_back('{resp: OKAY, rdata: 32'h0, pulse: 8'h01});
    model[0] = 32'hFFFFABCD;
    axi_wdata = 32'h1234ABCD; axi_wstrb = 4'h3; axi_wvalid = 1'b1;
    check("wfirst wready", axi_wready, 1'b1);
    tick();
    axi_wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("wfirst gap readies", {axi_awready, axi_wready, axi_bvalid}, 3'b100);
      check("wfirst gap reg0", cfg_regs[31:0], 32'hFFFFFFFF);
      tick();
    end
    axi_awaddr = 32'h0; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    wait_b("wfirst", 1'b1);

    // B backpressure: bvalid/bresp held, AW/W blocked until bready
    axi_bready = 1'b0;
    issue_write(32'h0000_0008, 32'hA5A5A5A5, 4'hF, OKAY);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp bvalid", axi_bvalid, 1'b1);
      check("bp bresp", axi_bresp, OKAY);
      check("bp aw/w ready", {axi_awready, axi_wready}, 2'b00);
      tick();
    end
    wait_b("bp_write", 1'b0);

    // R backpressure: rdata held even though the status input changes underneath
    sts_in[32*1 +: 32] = 32'h13572468;
    axi_rready = 1'b0;
    issue_read(32'h0000_0024, OKAY, 32'h13572468);
    sts_in[32*1 +: 32] = 32'h0;
    held_rdata = 32'h13572468;
    for (int c = 0; c < 5; c++) begin
      check("rp rvalid", axi_rvalid, 1'b1);
      check("rp rdata", axi_rdata, held_rdata);
      check("rp rresp", axi_rresp, OKAY);
      check("rp arready", axi_arready, 1'b0);
      tick();
    end
    wait_r("rp_read");
    check("rp arready after", axi_arready, 1'b1);

    // Read handshake on the commit edge of a write to the same register sees the old value
    axi_bready = 1'b0;
    issue_write(32'h0000_0014, 32'h77777777, 4'hF, OKAY);
    rq.push_back('{resp: OKAY, rdata: 32'h0, pulse: 8'h00});
    axi_araddr = 32'h0000_0014; axi_arvalid = 1'b1;
    check("collide arready", axi_arready, 1'b1);
    tick();
    axi_arvalid = 1'b0;
    check("collide bvalid", axi_bvalid, 1'b1);
    wait_r("collide_read");
    wait_b("collide_write", 1'b0);
    read_vec("collide_after", 32'h0000_0014, OKAY, 32'h77777777);

    // Reset while AW is held and W is still pending
    axi_awaddr = 32'h0000_0018; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    check("abort aw held", axi_awready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_CFG; i++) model[i] = '0;
    check_cfg("abort during reset");
    check("abort bvalid in reset", axi_bvalid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("abort readies", {axi_awready, axi_wready, axi_arready}, 3'b111);
    axi_bready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("abort no bvalid", axi_bvalid, 1'b0);
      check("abort no pulse", cfg_wr_pulse, 8'h00);
      tick();
    end
    check_cfg("abort after release");
    write_vec("abort_fresh", 32'h0000_0018, 32'h0000BEEF, 4'hF, OKAY);
    read_vec("abort_fresh_rd", 32'h0000_0018, OKAY, 32'h0000BEEF);

    check("wq drained", wq.size(), 0);
    check("rq drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
